// File: rtl/ws2812_rx.sv
// WS2812 single-wire NRZ receiver: synchronises the line, times each high pulse,
// slices bits against a runtime threshold, packs bytes MSB-first and detects frame-end low.
module ws2812_rx #(
  parameter int unsigned ADDR_WIDTH = 6,
  parameter int unsigned RST_SHIFT  = 4
) (
  input  logic                  clk_in,
  input  logic                  rst_in,
  input  logic                  ws2812_data_in,
  input  logic [7:0]            bit_thr_cnt_in,
  input  logic [7:0]            rst_cnt_in,
  output logic                  data_vld_out,
  output logic [7:0]            data_out,
  output logic [ADDR_WIDTH-1:0] addr_out,
  output logic                  frame_done_out,
  output logic [ADDR_WIDTH:0]   frame_len_out,
  output logic                  err_out
);

  localparam int unsigned   LW       = 8 + RST_SHIFT;
  localparam logic [LW-1:0] LCNT_MAX = '1;

  typedef enum logic [1:0] {SYNC, READY, HIGH, LOW} state_e;

  state_e                state_q, state_d;
  logic                  sync1_q, sync2_q, hist_q;
  logic [7:0]            hcnt_q, hcnt_d;
  logic [LW-1:0]         lcnt_q, lcnt_d;
  logic [7:0]            shift_q, shift_d;
  logic [2:0]            bit_cnt_q, bit_cnt_d;
  logic [ADDR_WIDTH:0]   byte_cnt_q, byte_cnt_d;
  logic                  err_clr_q, err_clr_d;
  logic                  data_vld_q, data_vld_d;
  logic [7:0]            data_q, data_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic                  frame_done_q, frame_done_d;
  logic [ADDR_WIDTH:0]   frame_len_q, frame_len_d;
  logic                  err_q, err_d;

  logic                  rise, fall, bit_val, frame_end;
  logic [7:0]            rst_eff, shift_in;
  logic [LW-1:0]         thr, thr_m1, lcnt_inc;

  always_comb begin
    rst_eff   = (rst_cnt_in == 8'd0) ? 8'd1 : rst_cnt_in;
    thr       = LW'(rst_eff) << RST_SHIFT;
    thr_m1    = thr - LW'(1);
    rise      = sync2_q & ~hist_q;
    fall      = ~sync2_q & hist_q;
    lcnt_inc  = (lcnt_q == LCNT_MAX) ? lcnt_q : lcnt_q + LW'(1);
    bit_val   = hcnt_q > bit_thr_cnt_in;
    shift_in  = {shift_q[6:0], bit_val};
    frame_end = lcnt_q >= thr;
  end

  always_comb begin
    state_d      = state_q;
    hcnt_d       = hcnt_q;
    lcnt_d       = lcnt_q;
    shift_d      = shift_q;
    bit_cnt_d    = bit_cnt_q;
    byte_cnt_d   = byte_cnt_q;
    err_clr_d    = 1'b0;
    data_vld_d   = 1'b0;
    data_d       = data_q;
    addr_d       = addr_q;
    frame_done_d = 1'b0;
    frame_len_d  = frame_len_q;
    err_d        = err_clr_q ? 1'b0 : err_q;

    case (state_q)
      SYNC: begin
        if (sync2_q) begin
          lcnt_d = '0;
        end else if (lcnt_q >= thr_m1) begin
          lcnt_d  = '0;
          state_d = READY;
        end else begin
          lcnt_d = lcnt_inc;
        end
      end

      READY: begin
        if (rise) begin
          hcnt_d  = 8'd1;
          state_d = HIGH;
        end
      end

      HIGH: begin
        if (fall) begin
          shift_d   = shift_in;
          bit_cnt_d = bit_cnt_q + 3'd1;
          lcnt_d    = LW'(1);
          state_d   = LOW;
          if (bit_cnt_q == 3'd7) begin
            if (!byte_cnt_q[ADDR_WIDTH]) begin
              data_vld_d = 1'b1;
              data_d     = shift_in;
              addr_d     = byte_cnt_q[ADDR_WIDTH-1:0];
              byte_cnt_d = byte_cnt_q + {{ADDR_WIDTH{1'b0}}, 1'b1};
            end else begin
              err_d = 1'b1;
            end
          end
        end else if (hcnt_q == 8'd254) begin
          hcnt_d     = 8'd255;
          err_d      = 1'b1;
          bit_cnt_d  = '0;
          shift_d    = '0;
          byte_cnt_d = '0;
          lcnt_d     = '0;
          state_d    = SYNC;
        end else begin
          hcnt_d = hcnt_q + 8'd1;
        end
      end

      LOW: begin
        // Frame end and a coincident rise are both honoured: close the frame, then time the new pulse.
        if (frame_end) begin
          frame_done_d = 1'b1;
          frame_len_d  = byte_cnt_q;
          err_clr_d    = 1'b1;
          if (bit_cnt_q != 3'd0) err_d = 1'b1;
          bit_cnt_d    = '0;
          shift_d      = '0;
          byte_cnt_d   = '0;
          lcnt_d       = '0;
          state_d      = READY;
        end
        if (rise) begin
          hcnt_d  = 8'd1;
          state_d = HIGH;
        end else if (!frame_end && !sync2_q) begin
          lcnt_d = lcnt_inc;
        end
      end

      default: state_d = SYNC;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q      <= SYNC;
      sync1_q      <= 1'b0;
      sync2_q      <= 1'b0;
      hist_q       <= 1'b0;
      hcnt_q       <= '0;
      lcnt_q       <= '0;
      shift_q      <= '0;
      bit_cnt_q    <= '0;
      byte_cnt_q   <= '0;
      err_clr_q    <= 1'b0;
      data_vld_q   <= 1'b0;
      data_q       <= '0;
      addr_q       <= '0;
      frame_done_q <= 1'b0;
      frame_len_q  <= '0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      sync1_q      <= ws2812_data_in;
      sync2_q      <= sync1_q;
      hist_q       <= sync2_q;
      hcnt_q       <= hcnt_d;
      lcnt_q       <= lcnt_d;
      shift_q      <= shift_d;
      bit_cnt_q    <= bit_cnt_d;
      byte_cnt_q   <= byte_cnt_d;
      err_clr_q    <= err_clr_d;
      data_vld_q   <= data_vld_d;
      data_q       <= data_d;
      addr_q       <= addr_d;
      frame_done_q <= frame_done_d;
      frame_len_q  <= frame_len_d;
      err_q        <= err_d;
    end
  end

  assign data_vld_out   = data_vld_q;
  assign data_out       = data_q;
  assign addr_out       = addr_q;
  assign frame_done_out = frame_done_q;
  assign frame_len_out  = frame_len_q;
  assign err_out        = err_q;

endmodule

// File: tb/tb_ws2812_rx.sv
// Directed bench for ws2812_rx: table of frames plus hand sequences for
// sync, timeout, overflow, coincident frame-end/rise and mid-bit reset.
module tb_ws2812_rx;

  logic       clk_in = 1'b0;
  logic       rst_in;
  logic       line;
  logic [7:0] bit_thr;
  logic [7:0] rst_cnt;

  logic       vld, fd, err;
  logic [7:0] dout;
  logic [5:0] addr;
  logic [6:0] flen;

  logic       vld2, fd2, err2;
  logic [7:0] dout2;
  logic [1:0] addr2;
  logic [2:0] flen2;

  ws2812_rx #(.ADDR_WIDTH(6), .RST_SHIFT(4)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .ws2812_data_in(line),
    .bit_thr_cnt_in(bit_thr), .rst_cnt_in(rst_cnt),
    .data_vld_out(vld), .data_out(dout), .addr_out(addr),
    .frame_done_out(fd), .frame_len_out(flen), .err_out(err)
  );

  ws2812_rx #(.ADDR_WIDTH(2), .RST_SHIFT(4)) dut2 (
    .clk_in(clk_in), .rst_in(rst_in), .ws2812_data_in(line),
    .bit_thr_cnt_in(bit_thr), .rst_cnt_in(rst_cnt),
    .data_vld_out(vld2), .data_out(dout2), .addr_out(addr2),
    .frame_done_out(fd2), .frame_len_out(flen2), .err_out(err2)
  );

  always #5 clk_in = ~clk_in;

  int tests = 0;
  int fails = 0;

  logic [31:0] sd[$], sa[$], fl[$], fe[$];
  logic [31:0] sd2[$], sa2[$], fl2[$], fe2[$];

  always @(negedge clk_in) begin
    if (vld)  begin sd.push_back(32'(dout));  sa.push_back(32'(addr));  end
    if (fd)   begin fl.push_back(32'(flen));  fe.push_back(32'(err));   end
    if (vld2) begin sd2.push_back(32'(dout2)); sa2.push_back(32'(addr2)); end
    if (fd2)  begin fl2.push_back(32'(flen2)); fe2.push_back(32'(err2));  end
  end

  typedef struct {
    int          nbits;
    logic [63:0] bits;
    int          exp_n;
    logic [63:0] exp_bytes;
    int          exp_len;
    logic        exp_err;
  } vec_t;

  vec_t vecs[5];

  task automatic wait_clks(input int n);
    repeat (n) @(posedge clk_in);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] qat(input logic [31:0] q[$], input int idx);
    if (idx < q.size()) return q[idx];
    return 'x;
  endfunction

  task automatic clear_q();
    sd.delete(); sa.delete(); fl.delete(); fe.delete();
    sd2.delete(); sa2.delete(); fl2.delete(); fe2.delete();
  endtask

  task automatic send_bit(input logic b, input int th1, input int th0, input int lo);
    line = 1'b1;
    wait_clks(b ? th1 : th0);
    line = 1'b0;
    wait_clks(lo);
  endtask

  task automatic send_bits(input logic [63:0] bits, input int n, input int th1,
                           input int th0, input int lo);
    for (int k = 0; k < n; k++) send_bit(bits[63-k], th1, th0, lo);
  endtask

  task automatic wait_fd(input int n, input int budget);
    int c;
    c = 0;
    while (fl.size() < n && c < budget) begin
      @(posedge clk_in);
      c++;
    end
    #1;
    if (fl.size() < n) begin
      tests++;
      fails++;
      $display("FAIL fd_timeout: got %0d frame_done expected %0d", fl.size(), n);
    end
  endtask

  task automatic chk_single(input string tag, input logic [7:0] b, input logic exp_err);
    chk({tag, "_nstrobe"}, 32'(sd.size()), 32'd1);
    chk({tag, "_data"}, qat(sd, 0), 32'(b));
    chk({tag, "_addr"}, qat(sa, 0), 32'd0);
    chk({tag, "_len"}, qat(fl, 0), 32'd1);
    chk({tag, "_err"}, qat(fe, 0), 32'(exp_err));
  endtask

  task automatic chk_outputs_zero(input string tag);
    chk({tag, "_vld"}, 32'(vld), 32'd0);
    chk({tag, "_data"}, 32'(dout), 32'd0);
    chk({tag, "_addr"}, 32'(addr), 32'd0);
    chk({tag, "_fd"}, 32'(fd), 32'd0);
    chk({tag, "_len"}, 32'(flen), 32'd0);
    chk({tag, "_err"}, 32'(err), 32'd0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] eb;
    logic [7:0]  ov_exp[4];

    vecs[0] = '{24, 64'hA500FF00_00000000, 3, 64'hA500FF00_00000000, 3, 1'b0};
    vecs[1] = '{12, 64'hC3500000_00000000, 1, 64'hC3000000_00000000, 1, 1'b1};
    vecs[2] = '{ 8, 64'h3C000000_00000000, 1, 64'h3C000000_00000000, 1, 1'b0};
    vecs[3] = '{16, 64'h80010000_00000000, 2, 64'h80010000_00000000, 2, 1'b0};
    vecs[4] = '{40, 64'h11223344_55000000, 5, 64'h11223344_55000000, 5, 1'b0};
    ov_exp  = '{8'h11, 8'h22, 8'h33, 8'h44};

    // Reset with the line high
    rst_in  = 1'b1;
    line    = 1'b1;
    bit_thr = 8'd28;
    rst_cnt = 8'd8;
    wait_clks(5);
    chk_outputs_zero("reset");
    rst_in = 1'b0;
    line   = 1'b0;
    wait_clks(200);

    for (int i = 0; i < 5; i++) begin
      clear_q();
      send_bits(vecs[i].bits, vecs[i].nbits, 40, 16, 24);
      wait_fd(1, 400);
      wait_clks(3);
      eb = vecs[i].exp_bytes;
      chk($sformatf("v%0d_nstrobe", i), 32'(sd.size()), 32'(vecs[i].exp_n));
      for (int k = 0; k < vecs[i].exp_n; k++) begin
        chk($sformatf("v%0d_data%0d", i, k), qat(sd, k), 32'(eb[63-8*k -: 8]));
        chk($sformatf("v%0d_addr%0d", i, k), qat(sa, k), 32'(k));
      end
      chk($sformatf("v%0d_nfd", i), 32'(fl.size()), 32'd1);
      chk($sformatf("v%0d_len", i), qat(fl, 0), 32'(vecs[i].exp_len));
      chk($sformatf("v%0d_err", i), qat(fe, 0), 32'(vecs[i].exp_err));
      chk($sformatf("v%0d_err_after", i), 32'(err), 32'd0);
    end

    // Narrow-index instance saw the 5-byte frame last
    chk("ovf_nstrobe", 32'(sd2.size()), 32'd4);
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("ovf_data%0d", k), qat(sd2, k), 32'(ov_exp[k]));
      chk($sformatf("ovf_addr%0d", k), qat(sa2, k), 32'(k));
    end
    chk("ovf_len", qat(fl2, 0), 32'd4);
    chk("ovf_err", qat(fe2, 0), 32'd1);

    // Bit-slice boundary: high 29 > 28 is a one, high 28 is a zero
    clear_q();
    send_bits({8'h5A, 56'h0}, 8, 29, 28, 24);
    wait_fd(1, 400);
    wait_clks(3);
    chk_single("thr_edge", 8'h5A, 1'b0);

    // High-pulse timeout, resync, then a clean byte
    clear_q();
    line = 1'b1;
    wait_clks(280);
    chk("timeout_err", 32'(err), 32'd1);
    wait_clks(20);
    line = 1'b0;
    wait_clks(130);
    send_bits({8'hE7, 56'h0}, 8, 40, 16, 24);
    wait_fd(1, 400);
    wait_clks(3);
    chk_single("timeout", 8'hE7, 1'b1);
    chk("timeout_err_after", 32'(err), 32'd0);

    // rst_cnt=0 -> threshold 16; a 16-clock gap lands frame end on the next rise
    rst_cnt = 8'd0;
    clear_q();
    send_bit(1'b1, 40, 16, 16);
    send_bits({8'h96, 56'h0}, 8, 40, 16, 12);
    wait_fd(2, 400);
    wait_clks(3);
    chk("coinc_nfd", 32'(fl.size()), 32'd2);
    chk("coinc_len0", qat(fl, 0), 32'd0);
    chk("coinc_err0", qat(fe, 0), 32'd1);
    chk("coinc_nstrobe", 32'(sd.size()), 32'd1);
    chk("coinc_data", qat(sd, 0), 32'h96);
    chk("coinc_addr", qat(sa, 0), 32'd0);
    chk("coinc_len1", qat(fl, 1), 32'd1);
    chk("coinc_err1", qat(fe, 1), 32'd0);
    rst_cnt = 8'd8;

    // Join mid-frame right after reset
    rst_in = 1'b1;
    line   = 1'b0;
    wait_clks(3);
    rst_in = 1'b0;
    clear_q();
    send_bits({8'hB0, 56'h0}, 5, 40, 16, 24);
    wait_clks(200);
    chk("join_nstrobe_pre", 32'(sd.size()), 32'd0);
    chk("join_nfd_pre", 32'(fl.size()), 32'd0);
    send_bits({8'h3C, 56'h0}, 8, 40, 16, 24);
    wait_fd(1, 400);
    wait_clks(3);
    chk_single("join", 8'h3C, 1'b0);

    // Reset asserted in the middle of bit 4
    clear_q();
    send_bits({8'hC0, 56'h0}, 3, 40, 16, 24);
    line = 1'b1;
    wait_clks(10);
    rst_in = 1'b1;
    wait_clks(1);
    chk_outputs_zero("midrst");
    rst_in = 1'b0;
    wait_clks(30);
    line = 1'b0;
    wait_clks(24);
    send_bits({8'hA0, 56'h0}, 4, 40, 16, 24);
    wait_clks(200);
    chk("midrst_nstrobe_pre", 32'(sd.size()), 32'd0);
    chk("midrst_nfd_pre", 32'(fl.size()), 32'd0);
    send_bits({8'h81, 56'h0}, 8, 40, 16, 24);
    wait_fd(1, 400);
    wait_clks(3);
    chk_single("midrst", 8'h81, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
